uart_host_seq: RTL and testbench
================================

// Module: uart_host_seq
// PURPOSE
//  Host-side UART sequencer that stands in front of the tester UART in the system bench.
//  It turns byte streams into native-bus register accesses (valid/addr/wdata/wstrb -> rdata/ready).
//  It replaces the task-based init/connect/sendfile traffic with a clocked engine, so console and boot-protocol generators only handle bytes.
//  It runs the init sequence, then serves TX and RX by polling TXREADY/RXREADY.
// PARAMETERS
//  ADDR_W      3        uart_addr width (UART_ADDR_W)
//  DATA_W      32       bus data width
//  DIV         100      baud divisor written at init (FREQ/BAUD)
//  TIMEOUT_CYC 1000000  cycles without progress before timeout (UART_HOST_TIMEOUT_EN only)
// PORTS
//  clk         in   1         clock
//  reset       in   1         synchronous, active-high reset
//  init_start  in   1         pulse: run the UART init sequence
//  init_done   out  1         high once init has completed; stays high until reset
//  tx_valid    in   1         byte to transmit is valid
//  tx_data     in   8         byte to transmit
//  tx_ready    out  1         tx byte accepted this cycle
//  rx_valid    out  1         received byte is valid
//  rx_data     out  8         received byte
//  rx_ready    in   1         consumer takes rx byte
//  uart_valid  out  1         bus request
//  uart_addr   out  ADDR_W    register word address
//  uart_wdata  out  DATA_W    write data
//  uart_wstrb  out  DATA_W/8  all-ones = write, zero = read
//  uart_rdata  in   DATA_W    read data, valid with uart_ready
//  uart_ready  in   1         access complete
//  timeout_err out  1         sticky timeout flag (tied 0 without UART_HOST_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values: state IDLE; outputs init_done, tx_ready, rx_valid, uart_valid and timeout_err are 0.
//    Reset also zeroes rx_data, uart_addr, uart_wdata, uart_wstrb and the rr pointer.
//  Bus rules:
//    - At most one access is in flight.
//    - addr/wdata/wstrb are stable while uart_valid=1.
//    - uart_valid falls the cycle after uart_ready is sampled high.
//    - No back-to-back gap is required.
//  Init sequence (starts on init_start in IDLE):
//    SRST1 writes SOFTRESET=1, then SRST0 (SOFTRESET=0), DIV (DIVISOR=DIV), TXEN=1, RXEN=1.
//    After the last write: init_done=1 and the FSM goes to SERVE.
//    init_start while not in IDLE is ignored.
//  SERVE: choose a job; an rr bit gives round-robin priority between TX and RX.
//    TX job is eligible when tx_valid=1. RX job is eligible when rx_valid=0.
//    With both eligible, the job opposite to the last completed one runs; rr flips on each completed job.
//  TX job:
//    - POLL_TX reads TXREADY. rdata[0]=0 -> back to SERVE. rdata[0]=1 -> WR_TX.
//    - WR_TX writes TXDATA={24'b0,tx_data}.
//    - tx_ready pulses 1 cycle in the cycle uart_ready completes the TXDATA write.
//  RX job:
//    - POLL_RX reads RXREADY. rdata[0]=0 -> back to SERVE. rdata[0]=1 -> RD_RX.
//    - RD_RX reads RXDATA. rx_data=rdata[7:0] and rx_valid=1 from the next cycle.
//    - rx_valid is held until rx_ready=1; it clears the cycle after.
//    - No further RX poll happens while rx_valid=1 (no byte is lost or overwritten).
//  tx_data is sampled when WR_TX is entered. If tx_valid drops mid-job, the committed write still completes and tx_ready still pulses.
//  Reset asserted mid-access: uart_valid=0 the next cycle and the pending response is discarded; the UART needs re-init.
// CONFIGURATION
//  UART_HOST_TIMEOUT_EN defined:
//    - A progress counter resets on every tx_ready pulse, every RXDATA read, and while in IDLE.
//    - When it reaches TIMEOUT_CYC during SERVE/INIT: timeout_err=1 (sticky) and the FSM enters ERR.
//    - ERR issues no bus traffic and leaves only on reset.
//  Not defined: no counter, timeout_err tied 0, and the FSM never enters ERR.
// STRUCTURE
//  Shared package uart_host_pkg:
//    - Register offsets: SOFTRESET=0, DIV=1, TXDATA=2, TXEN=3, TXREADY=4, RXDATA=5, RXEN=6, RXREADY=7.
//    - FSM state encoding: IDLE, SRST1, SRST0, DIV, TXEN, RXEN, SERVE, POLL_TX, WR_TX, POLL_RX, RD_RX, ERR.
//  One sub-module, uart_host_busport: a single-access native-bus master. It owns valid/addr/wdata/wstrb and returns a done pulse plus rdata.
// TESTING
//  1. init_start pulse with uart_ready=1 the cycle after each valid -> writes (0,1),(0,0),(1,100),(3,1),(6,1) in order; init_done=1 after the fifth.
//  2. tx_valid=1, tx_data=0x41; TXREADY reads 0,0,1 -> three reads of addr 4, one write of addr 2 with wdata 0x41, a single tx_ready pulse.
//  3. RXREADY=1, RXDATA=0x06, rx_ready=0 for 20 cycles -> rx_valid=1 with rx_data=0x06 held, and no reads of addr 7 while held.
//  4. tx_valid=1 and RX bytes pending together, both ready -> completed jobs alternate TX, RX, TX, RX.
//  5. reset=1 while uart_valid=1 and uart_ready=0 -> next cycle uart_valid=0, init_done=0, state IDLE.
//  6. UART_HOST_TIMEOUT_EN, TIMEOUT_CYC=50, TXREADY always 0 -> timeout_err=1 at cycle 50 of no progress, and uart_valid stays 0 afterwards.

Source files
------------

// File: rtl/uart_host_pkg.sv
// Shared definitions for the host-side UART sequencer: tester UART register
// word offsets, sequencer FSM states and round-robin job identifiers.
package uart_host_pkg;

    localparam logic [2:0] REG_SOFTRESET = 3'd0;
    localparam logic [2:0] REG_DIV       = 3'd1;
    localparam logic [2:0] REG_TXDATA    = 3'd2;
    localparam logic [2:0] REG_TXEN      = 3'd3;
    localparam logic [2:0] REG_TXREADY   = 3'd4;
    localparam logic [2:0] REG_RXDATA    = 3'd5;
    localparam logic [2:0] REG_RXEN      = 3'd6;
    localparam logic [2:0] REG_RXREADY   = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SRST1,
        ST_SRST0,
        ST_DIV,
        ST_TXEN,
        ST_RXEN,
        ST_SERVE,
        ST_POLL_TX,
        ST_WR_TX,
        ST_POLL_RX,
        ST_RD_RX,
        ST_ERR
    } state_t;

    typedef enum logic {
        JOB_TX = 1'b0,
        JOB_RX = 1'b1
    } job_t;

endpackage

// File: rtl/uart_host_busport.sv
// Single-access native-bus master: latches one request on start, holds it
// stable until uart_ready, and reports completion with a one-cycle done.
module uart_host_busport #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                abort,
    input  logic                start,
    input  logic                write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                done,
    output logic [DATA_W-1:0]   rdata,
    output logic                uart_valid,
    output logic [ADDR_W-1:0]   uart_addr,
    output logic [DATA_W-1:0]   uart_wdata,
    output logic [DATA_W/8-1:0] uart_wstrb,
    input  logic [DATA_W-1:0]   uart_rdata,
    input  logic                uart_ready
);

    logic                valid_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W/8-1:0] wstrb_reg;

    // A new start is only accepted while idle, so the request fields stay
    // frozen for the whole access and a completing access cannot be overrun.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else if (valid_reg) begin
            if (uart_ready) begin
                valid_reg <= 1'b0;
            end
        end else if (start) begin
            valid_reg <= 1'b1;
            addr_reg  <= addr;
            wdata_reg <= wdata;
            wstrb_reg <= write ? '1 : '0;
        end
    end

    assign done       = valid_reg & uart_ready;
    assign rdata      = uart_rdata;
    assign uart_valid = valid_reg;
    assign uart_addr  = addr_reg;
    assign uart_wdata = wdata_reg;
    assign uart_wstrb = wstrb_reg;

endmodule

// File: rtl/uart_host_seq.sv
// Host UART sequencer: runs the tester-UART init writes, then serves TX/RX bytes
// by polling TXREADY/RXREADY. Optional no-progress watchdog: UART_HOST_TIMEOUT_EN.
module uart_host_seq
    import uart_host_pkg::*;
#(
    parameter int          ADDR_W      = 3,
    parameter int          DATA_W      = 32,
    parameter int          DIV         = 100,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init_start,
    output logic                init_done,
    input  logic                tx_valid,
    input  logic [7:0]          tx_data,
    output logic                tx_ready,
    output logic                rx_valid,
    output logic [7:0]          rx_data,
    input  logic                rx_ready,
    output logic                uart_valid,
    output logic [ADDR_W-1:0]   uart_addr,
    output logic [DATA_W-1:0]   uart_wdata,
    output logic [DATA_W/8-1:0] uart_wstrb,
    input  logic [DATA_W-1:0]   uart_rdata,
    input  logic                uart_ready,
    output logic                timeout_err
);

    state_t              state_reg, state_next;
    job_t                rr_reg;
    logic                init_done_reg;
    logic                rx_valid_reg;
    logic [7:0]          rx_data_reg;
    logic [7:0]          tx_byte_reg;
    logic                bus_start, bus_write, bus_done;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata, bus_rdata;
    logic                timeout_hit;
    logic                tx_elig, rx_elig;
    logic                unused_rdata;

    assign unused_rdata = ^bus_rdata[DATA_W-1:8];
    assign tx_elig      = tx_valid;
    assign rx_elig      = !rx_valid_reg;

    uart_host_busport #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_busport (
        .clk        (clk),
        .reset      (reset),
        .abort      (timeout_hit),
        .start      (bus_start),
        .write      (bus_write),
        .addr       (bus_addr),
        .wdata      (bus_wdata),
        .done       (bus_done),
        .rdata      (bus_rdata),
        .uart_valid (uart_valid),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready)
    );

    always_comb begin
        state_next = state_reg;
        bus_start  = 1'b0;
        bus_write  = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        case (state_reg)
            ST_IDLE: if (init_start) state_next = ST_SRST1;
            ST_SRST1: begin
                bus_start = 1'b1; bus_write = 1'b1;
                bus_addr  = ADDR_W'(REG_SOFTRESET); bus_wdata = DATA_W'(1);
                if (bus_done) state_next = ST_SRST0;
            end
            ST_SRST0: begin
                bus_start = 1'b1; bus_write = 1'b1;
                bus_addr  = ADDR_W'(REG_SOFTRESET);
                if (bus_done) state_next = ST_DIV;
            end
            ST_DIV: begin
                bus_start = 1'b1; bus_write = 1'b1;
                bus_addr  = ADDR_W'(REG_DIV); bus_wdata = DATA_W'(DIV);
                if (bus_done) state_next = ST_TXEN;
            end
            ST_TXEN: begin
                bus_start = 1'b1; bus_write = 1'b1;
                bus_addr  = ADDR_W'(REG_TXEN); bus_wdata = DATA_W'(1);
                if (bus_done) state_next = ST_RXEN;
            end
            ST_RXEN: begin
                bus_start = 1'b1; bus_write = 1'b1;
                bus_addr  = ADDR_W'(REG_RXEN); bus_wdata = DATA_W'(1);
                if (bus_done) state_next = ST_SERVE;
            end
            ST_SERVE: begin
                if (tx_elig && (!rx_elig || rr_reg == JOB_TX)) state_next = ST_POLL_TX;
                else if (rx_elig)                              state_next = ST_POLL_RX;
            end
            ST_POLL_TX: begin
                bus_start = 1'b1; bus_addr = ADDR_W'(REG_TXREADY);
                if (bus_done) state_next = bus_rdata[0] ? ST_WR_TX : ST_SERVE;
            end
            ST_WR_TX: begin
                bus_start = 1'b1; bus_write = 1'b1;
                bus_addr  = ADDR_W'(REG_TXDATA); bus_wdata = DATA_W'(tx_byte_reg);
                if (bus_done) state_next = ST_SERVE;
            end
            ST_POLL_RX: begin
                bus_start = 1'b1; bus_addr = ADDR_W'(REG_RXREADY);
                if (bus_done) state_next = bus_rdata[0] ? ST_RD_RX : ST_SERVE;
            end
            ST_RD_RX: begin
                bus_start = 1'b1; bus_addr = ADDR_W'(REG_RXDATA);
                if (bus_done) state_next = ST_SERVE;
            end
            ST_ERR: state_next = ST_ERR;
            default: state_next = ST_IDLE;
        endcase
        if (timeout_hit) state_next = ST_ERR;
    end

    // rr always points at the job opposite to the last one that completed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            rr_reg        <= JOB_TX;
            init_done_reg <= 1'b0;
            rx_valid_reg  <= 1'b0;
            rx_data_reg   <= '0;
            tx_byte_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_RXEN && bus_done) init_done_reg <= 1'b1;
            if (state_reg == ST_POLL_TX && bus_done && bus_rdata[0]) tx_byte_reg <= tx_data;
            if (state_reg == ST_WR_TX && bus_done) rr_reg <= JOB_RX;
            if (state_reg == ST_RD_RX && bus_done) begin
                rr_reg       <= JOB_TX;
                rx_valid_reg <= 1'b1;
                rx_data_reg  <= bus_rdata[7:0];
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign tx_ready  = (state_reg == ST_WR_TX) && bus_done;
    assign init_done = init_done_reg;
    assign rx_valid  = rx_valid_reg;
    assign rx_data   = rx_data_reg;

`ifdef UART_HOST_TIMEOUT_EN
    logic [31:0] idle_cnt_reg;
    logic        timeout_err_reg;
    logic        progress;

    assign progress    = (state_reg == ST_IDLE) || tx_ready || (state_reg == ST_RD_RX && bus_done);
    assign timeout_hit = (state_reg != ST_ERR) && !progress && (idle_cnt_reg == TIMEOUT_CYC - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (progress || state_reg == ST_ERR) idle_cnt_reg <= '0;
            else if (!timeout_hit)               idle_cnt_reg <= idle_cnt_reg + 32'd1;
            if (timeout_hit) timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_host_seq.sv
// Self-checking bench for uart_host_seq: a modelled tester UART answers bus
// accesses and logs them into a queue that each scenario checks against expectations.
module tb_uart_host_seq;

    typedef struct packed {
        logic        write;
        logic [2:0]  addr;
        logic [31:0] wdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_start = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        rx_ready = 1'b0;
    logic [31:0] uart_rdata = 32'h0;
    logic        uart_ready = 1'b0;
    logic        init_done, tx_ready, rx_valid, uart_valid, timeout_err;
    logic [7:0]  rx_data;
    logic [2:0]  uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;

    int n_cmp = 0;
    int n_bad = 0;

    acc_t       act_q[$];
    acc_t       exp_q[$];
    logic       txready_q[$];
    logic       txready_default = 1'b1;
    logic [7:0] rx_bytes[$];
    logic [7:0] rx_exp_q[$];
    logic       job_q[$];
    logic       exp_job_q[$];

    uart_host_seq #(
        .ADDR_W      (3),
        .DATA_W      (32),
        .DIV         (100),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .init_start  (init_start),
        .init_done   (init_done),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .uart_valid  (uart_valid),
        .uart_addr   (uart_addr),
        .uart_wdata  (uart_wdata),
        .uart_wstrb  (uart_wstrb),
        .uart_rdata  (uart_rdata),
        .uart_ready  (uart_ready),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Tester UART model: answers each request one cycle after it appears.
    initial begin : responder
        logic wait_flag;
        acc_t a;
        wait_flag = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                uart_ready = 1'b0;
                wait_flag  = 1'b0;
            end else if (uart_ready) begin
                uart_ready = 1'b0;
            end else if (uart_valid) begin
                if (!wait_flag) begin
                    wait_flag = 1'b1;
                end else begin
                    wait_flag = 1'b0;
                    a.write = (uart_wstrb == 4'hF);
                    a.addr  = uart_addr;
                    a.wdata = uart_wdata;
                    act_q.push_back(a);
                    uart_rdata = $urandom;
                    if (!a.write) begin
                        case (a.addr)
                            3'd4: uart_rdata[0] = (txready_q.size() > 0) ? txready_q.pop_front() : txready_default;
                            3'd7: uart_rdata[0] = (rx_bytes.size() > 0);
                            3'd5: if (rx_bytes.size() > 0) begin
                                uart_rdata[7:0] = rx_bytes.pop_front();
                                job_q.push_back(1'b1);
                            end
                            default: ;
                        endcase
                    end else if (a.addr == 3'd2) begin
                        job_q.push_back(1'b0);
                    end
                    uart_ready = 1'b1;
                end
            end
        end
    end

    task automatic test_reset();
        int busy;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_cmp++; if (uart_valid !== 1'b0) begin n_bad++; $display("FAIL reset_uart_valid: got %b want 0", uart_valid); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        n_cmp++; if ({uart_addr, uart_wdata, uart_wstrb, rx_data} !== 47'd0) begin
            n_bad++; $display("FAIL reset_fields: got addr=%0d wdata=%h wstrb=%h rx_data=%h want all 0", uart_addr, uart_wdata, uart_wstrb, rx_data);
        end
        reset = 1'b0;
        busy = 0;
        repeat (10) begin @(negedge clk); if (uart_valid) busy++; end
        n_cmp++; if (busy !== 0) begin n_bad++; $display("FAIL idle_no_traffic: got %0d busy cycles want 0", busy); end
        $display("test_reset: done");
    endtask

    task automatic test_init();
        int   cyc;
        acc_t a, e;
        act_q.delete();
        exp_q.push_back('{1'b1, 3'd0, 32'd1});
        exp_q.push_back('{1'b1, 3'd0, 32'd0});
        exp_q.push_back('{1'b1, 3'd1, 32'd100});
        exp_q.push_back('{1'b1, 3'd3, 32'd1});
        exp_q.push_back('{1'b1, 3'd6, 32'd1});
        @(negedge clk); init_start = 1'b1;
        @(negedge clk); init_start = 1'b0;
        cyc = 0;
        while (!init_done && cyc < 200) begin @(negedge clk); cyc++; end
        n_cmp++; if (init_done !== 1'b1) begin n_bad++; $display("FAIL init_done: got %b want 1", init_done); end
        n_cmp++; if (act_q.size() != 5) begin n_bad++; $display("FAIL init_count: got %0d accesses want 5", act_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (act_q.size() > 0) ? act_q.pop_front() : '0;
            n_cmp++;
            if (a !== e) begin
                n_bad++; $display("FAIL init_access: got w=%b addr=%0d wdata=%0d want w=%b addr=%0d wdata=%0d", a.write, a.addr, a.wdata, e.write, e.addr, e.wdata);
            end else $display("init write addr=%0d wdata=%0d", a.addr, a.wdata);
        end
        act_q.delete();
    endtask

    task automatic test_tx();
        int   pulses;
        acc_t a, e;
        acc_t got_q[$];
        act_q.delete();
        txready_q.push_back(1'b0); txready_q.push_back(1'b0); txready_q.push_back(1'b1);
        exp_q.push_back('{1'b0, 3'd4, 32'd0});
        exp_q.push_back('{1'b0, 3'd4, 32'd0});
        exp_q.push_back('{1'b0, 3'd4, 32'd0});
        exp_q.push_back('{1'b1, 3'd2, 32'h41});
        tx_data = 8'h41; tx_valid = 1'b1;
        init_start = 1'b1;
        pulses = 0;
        repeat (300) begin
            @(negedge clk);
            init_start = 1'b0;
            if (tx_ready) begin pulses++; tx_valid = 1'b0; tx_data = 8'h99; end
        end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL tx_ready_pulses: got %0d want 1", pulses); end
        foreach (act_q[i]) if (act_q[i].write || act_q[i].addr != 3'd7) got_q.push_back(act_q[i]);
        n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL tx_access_count: got %0d want 4", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (got_q.size() > 0) ? got_q.pop_front() : '0;
            n_cmp++;
            if (a.write !== e.write || a.addr !== e.addr || (e.write && a.wdata !== e.wdata)) begin
                n_bad++; $display("FAIL tx_access: got w=%b addr=%0d wdata=%h want w=%b addr=%0d wdata=%h", a.write, a.addr, a.wdata, e.write, e.addr, e.wdata);
            end else $display("tx access w=%b addr=%0d wdata=%h", a.write, a.addr, a.wdata);
        end
        act_q.delete();
    endtask

    task automatic test_rx_hold();
        int         cyc, held_bad, polls;
        logic [7:0] e;
        rx_ready = 1'b0;
        rx_bytes.push_back(8'h06);
        rx_exp_q.push_back(8'h06);
        cyc = 0;
        while (!rx_valid && cyc < 200) begin @(negedge clk); cyc++; end
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx_valid_seen: got %b want 1", rx_valid); end
        e = rx_exp_q.pop_front();
        n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL rx_data: got %h want %h", rx_data, e); end
        else $display("rx byte %h received", rx_data);
        act_q.delete();
        held_bad = 0;
        repeat (20) begin @(negedge clk); if (rx_valid !== 1'b1 || rx_data !== e) held_bad++; end
        n_cmp++; if (held_bad != 0) begin n_bad++; $display("FAIL rx_hold: got %0d bad cycles want 0", held_bad); end
        polls = 0;
        foreach (act_q[i]) if (!act_q[i].write && act_q[i].addr == 3'd7) polls++;
        n_cmp++; if (polls != 0) begin n_bad++; $display("FAIL rx_no_poll: got %0d RXREADY reads want 0", polls); end
    endtask

    task automatic test_round_robin();
        int         tx_idx;
        logic [7:0] e;
        job_q.delete();
        exp_job_q.push_back(1'b0); exp_job_q.push_back(1'b1);
        exp_job_q.push_back(1'b0); exp_job_q.push_back(1'b1);
        rx_bytes.push_back(8'hA1); rx_bytes.push_back(8'hA2);
        rx_exp_q.push_back(8'hA1); rx_exp_q.push_back(8'hA2);
        tx_idx = 0; tx_data = 8'h51; tx_valid = 1'b1;
        rx_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rx_release: got %b want 0", rx_valid); end
        repeat (400) begin
            if (tx_ready) begin
                tx_idx++;
                if (tx_idx >= 2) tx_valid = 1'b0; else tx_data = 8'h52;
            end
            if (rx_valid) begin
                if (rx_exp_q.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL rr_rx_extra: got %h want none", rx_data);
                end else begin
                    e = rx_exp_q.pop_front();
                    n_cmp++; if (rx_data !== e) begin n_bad++; $display("FAIL rr_rx_data: got %h want %h", rx_data, e); end
                    else $display("rr rx byte %h", rx_data);
                end
            end
            @(negedge clk);
        end
        n_cmp++; if (tx_idx != 2) begin n_bad++; $display("FAIL rr_tx_count: got %0d want 2", tx_idx); end
        n_cmp++; if (rx_exp_q.size() != 0) begin n_bad++; $display("FAIL rr_rx_count: got %0d left want 0", rx_exp_q.size()); end
        n_cmp++; if (job_q.size() != 4) begin n_bad++; $display("FAIL rr_job_count: got %0d want 4", job_q.size()); end
        foreach (exp_job_q[i]) begin
            n_cmp++;
            if (i >= job_q.size() || job_q[i] !== exp_job_q[i]) begin
                n_bad++; $display("FAIL rr_order[%0d]: got %s want %s", i, (i < job_q.size()) ? (job_q[i] ? "RX" : "TX") : "none", exp_job_q[i] ? "RX" : "TX");
            end else $display("rr job %0d = %s", i, job_q[i] ? "RX" : "TX");
        end
        exp_job_q.delete();
    endtask

    task automatic test_reset_mid_access();
        int found, busy;
        found = 0;
        repeat (50) begin
            if (found == 0) begin
                @(negedge clk);
                if (uart_valid && !uart_ready) found = 1;
            end
        end
        n_cmp++; if (found != 1) begin n_bad++; $display("FAIL mid_access_seen: got %0d want 1", found); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (uart_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_valid: got %b want 0", uart_valid); end
        n_cmp++; if (init_done !== 1'b0) begin n_bad++; $display("FAIL mid_reset_init_done: got %b want 0", init_done); end
        n_cmp++; if (uart_wstrb !== 4'h0 || uart_addr !== 3'd0) begin
            n_bad++; $display("FAIL mid_reset_fields: got addr=%0d wstrb=%h want 0", uart_addr, uart_wstrb);
        end
        @(negedge clk); reset = 1'b0;
        busy = 0;
        repeat (10) begin @(negedge clk); if (uart_valid) busy++; end
        n_cmp++; if (busy != 0) begin n_bad++; $display("FAIL mid_reset_idle: got %0d busy cycles want 0", busy); end
        $display("test_reset_mid_access: done");
    endtask

    task automatic test_timeout();
        int cyc, init_seen, busy;
        act_q.delete();
        txready_default = 1'b0;
        tx_data = 8'h77; tx_valid = 1'b1;
        @(negedge clk); init_start = 1'b1;
        cyc = 0; init_seen = 0;
`ifdef UART_HOST_TIMEOUT_EN
        while (!timeout_err && cyc < 200) begin
            @(negedge clk); cyc++;
            init_start = 1'b0;
            if (init_done) init_seen = 1;
        end
        n_cmp++; if (init_seen != 1) begin n_bad++; $display("FAIL to_init: got %0d want 1", init_seen); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b want 1", timeout_err); end
        n_cmp++; if (cyc < 49 || cyc > 53) begin n_bad++; $display("FAIL to_latency: got %0d cycles want 49..53", cyc); end
        busy = 0;
        repeat (30) begin if (uart_valid || !timeout_err) busy++; @(negedge clk); end
        n_cmp++; if (busy != 0) begin n_bad++; $display("FAIL to_err_quiet: got %0d bad cycles want 0", busy); end
`else
        busy = 0;
        while (cyc < 150) begin
            @(negedge clk); cyc++;
            init_start = 1'b0;
            if (init_done) init_seen = 1;
            if (timeout_err) init_seen = 2;
            if (uart_valid) busy++;
        end
        n_cmp++; if (init_seen != 1) begin n_bad++; $display("FAIL to_disabled_flag: got state %0d want 1", init_seen); end
        n_cmp++; if (busy == 0) begin n_bad++; $display("FAIL to_disabled_traffic: got 0 busy cycles want >0"); end
`endif
        tx_valid = 1'b0;
        $display("test_timeout: done after %0d cycles", cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init();
        test_tx();
        test_rx_hold();
        test_round_robin();
        test_reset_mid_access();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
